// File: rtl/cnn_mac_acc_10s_24.sv
// cnn_mac_acc_10s_24: accumulates KERNEL_N signed products plus a per-window
// bias, then rounds half-up, shifts right by SHIFT and saturates to OUT_W bits.
// Optional build macro: CNN_MAC_ACC_RELU_EN (fuses a ReLU after rounding).
// Ports:
//   ap_clk, ap_rst_n            clock, async active-low reset
//   in_valid/in_ready/in_prod   product stream (signed PROD_W)
//   bias                        signed BIAS_W, sampled on tap 0 only
//   out_valid/out_ready         result handshake
//   out_data/out_sat            signed OUT_W result, saturation flag
module cnn_mac_acc_10s_24 #(
  parameter int KERNEL_N = 9,
  parameter int PROD_W   = 24,
  parameter int ACC_W    = 32,
  parameter int BIAS_W   = 16,
  parameter int SHIFT    = 14,
  parameter int OUT_W    = 10
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic signed [BIAS_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat
);

  localparam int CNT_W =
    (KERNEL_N > 1) ? $clog2(KERNEL_N) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP =
    CNT_W'(KERNEL_N - 1);

  localparam logic [0:0] S_ACC = 1'b0;
  localparam logic [0:0] S_OUT = 1'b1;

  // Rounding/clip constants at ACC_W+1 bits so the
  // rounding add can never overflow.
  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W + 1 - SHIFT){1'b0}}, 1'b1,
     {(SHIFT - 1){1'b0}}};
  localparam logic signed [ACC_W:0] OUT_MAX =
    {{(ACC_W - OUT_W + 2){1'b0}},
     {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN =
    {{(ACC_W - OUT_W + 2){1'b1}},
     {(OUT_W - 1){1'b0}}};

  logic [0:0]              r_state;
  logic [CNT_W-1:0]        r_tap;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_sat;

  logic                    w_in_xfer;
  logic                    w_out_xfer;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_bias_x;
  logic signed [ACC_W-1:0] w_prod_x;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_r;
  logic signed [OUT_W-1:0] w_res;
  logic                    w_sat;

  // in_ready is only ever high in S_ACC, so the
  // handshake alone gates every acc update and an
  // idle (possibly X) in_prod never reaches state.
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_last     = (r_tap == LAST_TAP);

  assign w_bias_x =
    {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias};
  assign w_prod_x =
    {{(ACC_W - PROD_W){in_prod[PROD_W-1]}}, in_prod};

  // Tap 0 restarts from the bias instead of acc.
  assign w_base = (r_tap == '0) ? w_bias_x : r_acc;
  assign w_sum  = w_base + w_prod_x;

  assign w_rnd = {w_sum[ACC_W-1], w_sum} + RND;
  assign w_r   = w_rnd >>> SHIFT;

  always_comb begin
    w_res = w_r[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_r > OUT_MAX) begin
      w_res = OUT_MAX[OUT_W-1:0];
      w_sat = 1'b1;
`ifdef CNN_MAC_ACC_RELU_EN
    end else if (w_r[ACC_W]) begin
      w_res = '0;
      w_sat = 1'b0;
`else
    end else if (w_r < OUT_MIN) begin
      w_res = OUT_MIN[OUT_W-1:0];
      w_sat = 1'b1;
`endif
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= S_ACC;
      r_tap       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      unique case (r_state)
        S_ACC: begin
          r_in_ready <= 1'b1;
          if (w_in_xfer) begin
            r_acc <= w_sum;
            if (w_last) begin
              r_tap       <= '0;
              r_out_data  <= w_res;
              r_out_sat   <= w_sat;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= S_OUT;
            end else begin
              r_tap <= r_tap + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACC;
          end
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_cnn_mac_acc_10s_24.sv
// tb_cnn_mac_acc_10s_24: directed plus randomized windows for
// cnn_mac_acc_10s_24 against an arithmetic reference model.
module tb_cnn_mac_acc_10s_24;

  localparam int KN     = 9;
  localparam int PROD_W = 24;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 10;
  localparam int SHIFT  = 14;

  logic                     ap_clk;
  logic                     ap_rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_prod;
  logic signed [BIAS_W-1:0] bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;

  int     checks;
  int     failures;
  longint prods [KN];
  longint ed;
  longint es;
  longint nb;

  cnn_mac_acc_10s_24 dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Reference: full-precision sum, floor((s + half) / 2^SHIFT), clip.
  task automatic model(input longint b,
                       output longint d,
                       output longint s);
    longint sum;
    longint r;
    longint hi;
    longint lo;
    sum = b;
    for (int j = 0; j < KN; j++) sum += prods[j];
    r  = (sum + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    lo = -(64'sd1 <<< (OUT_W - 1));
    d = r;
    s = 0;
    if (r > hi) begin
      d = hi;
      s = 1;
    end else if (r < lo) begin
`ifdef CNN_MAC_ACC_RELU_EN
      d = 0;
      s = 0;
`else
      d = lo;
      s = 1;
`endif
    end
`ifdef CNN_MAC_ACC_RELU_EN
    if (r < 0) begin
      d = 0;
      s = 0;
    end
`endif
  endtask

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic longint rnd_bias();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic longint rnd_prod();
    longint p;
    p = longint'($urandom_range(0, 32'hFFFFFF)) - 8388608;
    return p >>> $urandom_range(0, 12);
  endfunction

  task automatic send_prod(input longint p,
                           input longint b);
    int n;
    in_valid = 1'b1;
    in_prod  = PROD_W'(p);
    bias     = BIAS_W'(b);
    n = 0;
    while (!in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    cyc();
    in_valid = 1'b0;
    in_prod  = PROD_W'(rnd_prod());
    bias     = BIAS_W'(rnd_bias());
  endtask

  task automatic send_window(input longint b,
                             input int gap_max);
    for (int j = 0; j < KN; j++) begin
      if (j > 0 && gap_max > 0)
        repeat ($urandom_range(0, gap_max)) cyc();
      send_prod(prods[j], (j == 0) ? b : rnd_bias());
    end
    chk("valid_latency", longint'(out_valid), 1);
  endtask

  task automatic recv(input string tag,
                      input longint b,
                      input int hold);
    longint d;
    longint s;
    model(b, d, s);
    for (int k = 0; k < hold; k++) begin
      chk({tag, "_hold_valid"}, longint'(out_valid), 1);
      chk({tag, "_hold_ready"}, longint'(in_ready), 0);
      chk({tag, "_hold_data"}, longint'(out_data), d);
      cyc();
    end
    chk({tag, "_data"}, longint'(out_data), d);
    chk({tag, "_sat"}, longint'(out_sat), s);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({tag, "_drop"}, longint'(out_valid), 0);
  endtask

  task automatic fill(input longint v);
    for (int j = 0; j < KN; j++) prods[j] = v;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    bias      = '0;
    out_ready = 1'b0;

    repeat (3) cyc();
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_sat", longint'(out_sat), 0);
    chk("rst_ready", longint'(in_ready), 0);
    ap_rst_n = 1'b1;
    #1;
    chk("rel_ready0", longint'(in_ready), 0);
    cyc();
    chk("rel_ready1", longint'(in_ready), 1);

    fill(16384);
    send_window(0, 0);
    chk("basic_const", longint'(out_data), 9);
    recv("basic", 0, 0);

    fill(0);
    prods[0] = 8191;
    send_window(8192, 0);
    chk("round_a_const", longint'(out_data), 1);
    recv("round_a", 8192, 0);
    prods[0] = 8190;
    send_window(8192, 0);
    recv("round_b", 8192, 0);
    fill(0);
    send_window(-8193, 0);
    recv("round_c", -8193, 0);

    fill(8388607);
    send_window(32767, 0);
    chk("satp_const", longint'(out_data), 511);
    recv("sat_pos", 32767, 0);
    fill(-8388608);
    send_window(-32768, 0);
    recv("sat_neg", -32768, 0);

    fill(16384);
    send_window(0, 2);
    chk("gaps_const", longint'(out_data), 9);
    recv("gaps", 0, 5);

    // Next window offered while the result is still pending.
    fill(16384);
    send_window(0, 0);
    for (int j = 0; j < KN; j++) prods[j] = rnd_prod();
    nb = rnd_bias();
    in_valid = 1'b1;
    in_prod  = PROD_W'(prods[0]);
    bias     = BIAS_W'(nb);
    for (int k = 0; k < 3; k++) begin
      chk("block_ready", longint'(in_ready), 0);
      chk("block_data", longint'(out_data), 9);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("block_drop", longint'(out_valid), 0);
    chk("block_reopen", longint'(in_ready), 1);
    send_window(nb, 0);
    recv("block_next", nb, 2);

    // out_ready held high across a whole window.
    for (int j = 0; j < KN; j++) prods[j] = rnd_prod();
    nb = rnd_bias();
    out_ready = 1'b1;
    send_window(nb, 0);
    model(nb, ed, es);
    chk("rdyhi_data", longint'(out_data), ed);
    chk("rdyhi_sat", longint'(out_sat), es);
    cyc();
    chk("rdyhi_drop", longint'(out_valid), 0);
    out_ready = 1'b0;

    // Reset with a partial window in flight.
    fill(16384);
    for (int j = 0; j < 4; j++) send_prod(prods[j], 0);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_ready", longint'(in_ready), 0);
    repeat (2) cyc();
    ap_rst_n = 1'b1;
    repeat (3) cyc();
    chk("mid_rst_noout", longint'(out_valid), 0);
    send_window(0, 0);
    chk("mid_rst_const", longint'(out_data), 9);
    recv("mid_rst", 0, 0);

    for (int w = 0; w < 20; w++) begin
      for (int j = 0; j < KN; j++) prods[j] = rnd_prod();
      nb = rnd_bias();
      send_window(nb, $urandom_range(0, 2));
      recv("rand", nb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
